// File: rtl/sum_uart_tx.sv
// Byte FIFO (4 entries) feeding a UART 8N1 transmitter. Frames start only when
// ena is high; the FIFO accepts bytes regardless of ena.
module sum_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] sum_in,
  input  logic       sum_valid,
  output logic       sum_ready,
  output logic       tx,
  output logic       busy,
  output logic [2:0] fifo_count,
  output logic       overflow
);

  localparam int unsigned     CW         = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CNT_MAX    = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      FULL_COUNT = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [1:0]    wr_ptr_q, wr_ptr_d;
  logic [1:0]    rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          push, pop;

  // Ready comes from the pre-edge count, so a push while full is refused
  // even when a pop happens on the same edge.
  assign sum_ready  = (count_q != FULL_COUNT);
  assign push       = sum_valid && sum_ready;
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        bit_d = '0;
        if (ena && (count_q != 3'd0)) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            // tx is registered, so the next bit is taken one position ahead
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d   = wr_ptr_q + 2'(push);
    rd_ptr_d   = rd_ptr_q + 2'(pop);
    count_d    = count_q + 3'(push) - 3'(pop);
    overflow_d = overflow_q | (sum_valid & ~sum_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= sum_in;
    end
  end

endmodule
